// File: rtl/life_board_scanner.sv
// life_board_scanner: takes a snapshot of the 8x8 Life board once per frame and
// scans it onto an LED matrix one row at a time. Every FRAMES_PER_GEN frames it
// emits step_tick, which paces the game generations.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | one cycle: capture board_in into the snapshot, restart at row 0
// SCAN  | DWELL cycles: drive row_idx and its snapshot columns
// GAP   | GAP cycles: blank the matrix, then go to the next row or to LOAD
module life_board_scanner #(
    parameter int DWELL          = 1000,
    parameter int GAP            = 4,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] board_in,
    input  logic        blank,
    output logic [7:0]  row_sel,
    output logic [7:0]  col_data,
    output logic        frame_start,
    output logic        step_tick
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t         state;
    logic [2:0]     row_idx;
    logic [DW-1:0]  dwell_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [FW-1:0]  frame_cnt;
    logic [63:0]    snapshot;
    logic           row_done;
    logic           lit;

    // A row finishes at the end of its gap, or at the end of its dwell when there is no gap.
    assign row_done = ((state == ST_SCAN) && (dwell_cnt == DWELL_LAST) && (GAP == 0)) ||
                      ((state == ST_GAP) && (gap_cnt == GAP_LAST));

    // Sequencer: LOAD -> SCAN -> GAP -> SCAN ... row 7 -> LOAD, and frame/generation pacing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_LOAD;
            row_idx   <= 3'd0;
            dwell_cnt <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            snapshot  <= 64'd0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            case (state)
                ST_LOAD: begin
                    snapshot  <= board_in;
                    row_idx   <= 3'd0;
                    dwell_cnt <= '0;
                    gap_cnt   <= '0;
                    state     <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (GAP != 0) begin
                            state <= ST_GAP;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase

            // Row advance overrides the per-state next-state choice above.
            if (row_done) begin
                if (row_idx == 3'd7) begin
                    state <= ST_LOAD;
                    if (frame_cnt == FRAME_LAST) begin
                        frame_cnt <= '0;
                        step_tick <= 1'b1;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end else begin
                    row_idx <= row_idx + 3'd1;
                    state   <= ST_SCAN;
                end
            end
        end
    end

    // Matrix drive comes only from registered state and snapshot; blank is the one live gate.
    assign lit         = (state == ST_SCAN) && !blank;
    assign row_sel     = lit ? (8'b1 << row_idx) : 8'h00;
    assign col_data    = lit ? snapshot[{row_idx, 3'b000} +: 8] : 8'h00;
    assign frame_start = (state == ST_SCAN) && (row_idx == 3'd0) && (dwell_cnt == '0);

endmodule
